// File: rtl/operand_fetch.sv
// Operand fetch / issue stage in front of the 3R/1W register file.
// Tracks in-flight writers in a pending scoreboard, stalls on RAW/WAW
// hazards, forwards same-cycle writeback data and registers the
// selected operands for the execute stage.

// Per-operand lane: hazard detection and operand mux for one source.
module operand_fetch_lane #(
    parameter int NUM_ADDR_BITS = 6,
    parameter int REG_WIDTH     = 32,
    parameter int NUM_REGS      = 2**NUM_ADDR_BITS
) (
    input  logic [NUM_ADDR_BITS-1:0] i_src,
    input  logic [REG_WIDTH-1:0]     i_rd_data,
    input  logic [NUM_REGS-1:0]      i_pend_eff,
    input  logic                     i_wb_valid,
    input  logic [NUM_ADDR_BITS-1:0] i_wb_addr,
    input  logic [REG_WIDTH-1:0]     i_wb_data,
    output logic                     o_raw,
    output logic [REG_WIDTH-1:0]     o_op
);
    logic w_src_nz;

    assign w_src_nz = (i_src != '0);
    assign o_raw    = w_src_nz & i_pend_eff[i_src];

    // Register 0 reads as zero; a matching writeback beats the stale regfile read.
    always_comb begin
        o_op = i_rd_data;
        if (!w_src_nz)
            o_op = '0;
        else if (i_wb_valid && (i_wb_addr == i_src))
            o_op = i_wb_data;
    end
endmodule

module operand_fetch #(
    parameter int NUM_ADDR_BITS = 6,
    parameter int REG_WIDTH     = 32,
    parameter int NUM_REGS      = 2**NUM_ADDR_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [NUM_ADDR_BITS-1:0] inSrcA,
    input  logic [NUM_ADDR_BITS-1:0] inSrcB,
    input  logic [NUM_ADDR_BITS-1:0] inSrcC,
    input  logic [NUM_ADDR_BITS-1:0] inDst,
    input  logic                     inWritesDst,
    output logic [NUM_ADDR_BITS-1:0] rdAddrA,
    output logic [NUM_ADDR_BITS-1:0] rdAddrB,
    output logic [NUM_ADDR_BITS-1:0] rdAddrC,
    input  logic [REG_WIDTH-1:0]     rdDataA,
    input  logic [REG_WIDTH-1:0]     rdDataB,
    input  logic [REG_WIDTH-1:0]     rdDataC,
    input  logic                     wbValid,
    input  logic [NUM_ADDR_BITS-1:0] wbAddr,
    input  logic [REG_WIDTH-1:0]     wbData,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [REG_WIDTH-1:0]     outOpA,
    output logic [REG_WIDTH-1:0]     outOpB,
    output logic [REG_WIDTH-1:0]     outOpC,
    output logic [NUM_ADDR_BITS-1:0] outDst,
    output logic                     outWritesDst,
    output logic                     busy
);
    localparam int NUM_OPS = 3;
    localparam logic [NUM_REGS-1:0] ONE_HOT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

    logic [NUM_REGS-1:0]                     r_pending;
    logic                                    r_out_valid;
    logic [NUM_OPS-1:0][REG_WIDTH-1:0]       r_out_op;
    logic [NUM_ADDR_BITS-1:0]                r_out_dst;
    logic                                    r_out_wr;

    logic [NUM_REGS-1:0]                     w_wb_clr;
    logic [NUM_REGS-1:0]                     w_iss_set;
    logic [NUM_REGS-1:0]                     w_pend_eff;
    logic [NUM_OPS-1:0][NUM_ADDR_BITS-1:0]   w_src;
    logic [NUM_OPS-1:0][REG_WIDTH-1:0]       w_rd;
    logic [NUM_OPS-1:0][REG_WIDTH-1:0]       w_op;
    logic [NUM_OPS-1:0]                      w_raw;
    logic                                    w_waw;
    logic                                    w_hazard;
    logic                                    w_issue;
    logic                                    w_dst_tracked;

    assign rdAddrA = inSrcA;
    assign rdAddrB = inSrcB;
    assign rdAddrC = inSrcC;

    assign w_src = {inSrcC, inSrcB, inSrcA};
    assign w_rd  = {rdDataC, rdDataB, rdDataA};

    // Writeback clears its pending bit in the same cycle so a waiting reader can issue.
    assign w_wb_clr   = wbValid ? (ONE_HOT0 << wbAddr) : '0;
    assign w_pend_eff = r_pending & ~w_wb_clr;

    genvar g;
    generate
        for (g = 0; g < NUM_OPS; g++) begin : g_lane
            operand_fetch_lane #(
                .NUM_ADDR_BITS(NUM_ADDR_BITS),
                .REG_WIDTH    (REG_WIDTH),
                .NUM_REGS     (NUM_REGS)
            ) u_lane (
                .i_src     (w_src[g]),
                .i_rd_data (w_rd[g]),
                .i_pend_eff(w_pend_eff),
                .i_wb_valid(wbValid),
                .i_wb_addr (wbAddr),
                .i_wb_data (wbData),
                .o_raw     (w_raw[g]),
                .o_op      (w_op[g])
            );
        end
    endgenerate

    // Register 0 is never tracked, so it neither stalls nor becomes pending.
    assign w_dst_tracked = inWritesDst & (inDst != '0);
    assign w_waw         = w_dst_tracked & w_pend_eff[inDst];
    assign w_hazard      = (|w_raw) | w_waw;
    assign inReady       = ~w_hazard & (~r_out_valid | outReady);
    assign w_issue       = inValid & inReady;
    assign w_iss_set     = (w_issue & w_dst_tracked) ? (ONE_HOT0 << inDst) : '0;

    // Scoreboard: clear on writeback, set on issue; set applied last so a new writer wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_pending <= '0;
        else
            r_pending <= (r_pending & ~w_wb_clr) | w_iss_set;
    end

    // Output pipeline register: load on issue, drain on outReady, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_op    <= '0;
            r_out_dst   <= '0;
            r_out_wr    <= 1'b0;
        end else if (w_issue) begin
            r_out_valid <= 1'b1;
            r_out_op    <= w_op;
            r_out_dst   <= inDst;
            r_out_wr    <= inWritesDst;
        end else if (outReady) begin
            r_out_valid <= 1'b0;
        end
    end

    assign outValid     = r_out_valid;
    assign outOpA       = r_out_op[0];
    assign outOpB       = r_out_op[1];
    assign outOpC       = r_out_op[2];
    assign outDst       = r_out_dst;
    assign outWritesDst = r_out_wr;
    assign busy         = |r_pending;
endmodule
